// File: rtl/fifo_pkg.sv
// Shared defaults and address-width helper for the single-clock FIFO.
package fifo_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int DEPTH_DEF = 16;

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_if.sv
// Write/read handshake bundle for the FIFO; slave is the FIFO side, master the producer/consumer side.
interface fifo_if
    import fifo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);

    logic [WIDTH-1:0] din;
    logic             wr_en;
    logic             full;
    logic             almost_full;
    logic             wr_ack;
    logic             wr_err;
    logic             rd_en;
    logic [WIDTH-1:0] dout;
    logic             empty;
    logic             almost_empty;
    logic             rd_ack;
    logic             rd_err;

    modport master (
        output din, wr_en, rd_en,
        input  full, almost_full, wr_ack, wr_err,
        input  dout, empty, almost_empty, rd_ack, rd_err
    );

    modport slave (
        input  din, wr_en, rd_en,
        output full, almost_full, wr_ack, wr_err,
        output dout, empty, almost_empty, rd_ack, rd_err
    );

endinterface

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH register array: synchronous write port, registered read port cleared by clear.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                      clk,
    input  logic                      clear,
    input  logic                      we,
    input  logic [addr_w(DEPTH)-1:0]  waddr,
    input  logic [WIDTH-1:0]          wdata,
    input  logic                      re,
    input  logic [addr_w(DEPTH)-1:0]  raddr,
    output logic [WIDTH-1:0]          rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // storage array write; contents are left untouched by clear
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // read register; holds its value when no read is accepted
    always_ff @(posedge clk) begin
        if (clear) begin
            rdata <= {WIDTH{1'b0}};
        end else if (re) begin
            rdata <= mem_r[raddr];
        end
    end

endmodule

// File: rtl/fifo_modport.sv
// Single-clock FIFO with per-request ack/err; flags decode from a registered count.
// Optional DATA_COUNT_EN adds a data_count output mirroring the internal count.
module fifo_modport
    import fifo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     wr_clk,
    input  logic                     clear,
    fifo_if.slave                    fif
`ifdef DATA_COUNT_EN
    ,
    output logic [addr_w(DEPTH):0]   data_count
`endif
);

    localparam int AW = addr_w(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] count_r;
    logic [PW-1:0] count_nxt_s;
    logic          wr_ack_r;
    logic          wr_err_r;
    logic          rd_ack_r;
    logic          rd_err_r;
    logic          full_s;
    logic          almost_full_s;
    logic          empty_s;
    logic          almost_empty_s;
    logic          wr_accept_s;
    logic          rd_accept_s;

    // status flags and acceptance decode from the current count
    always_comb begin
        full_s         = (count_r == PW'(DEPTH));
        almost_full_s  = (count_r >= PW'(DEPTH - 1));
        empty_s        = (count_r == {PW{1'b0}});
        almost_empty_s = (count_r <= PW'(1));
        wr_accept_s    = fif.wr_en & ~full_s;
        rd_accept_s    = fif.rd_en & ~empty_s;
    end

    // occupancy update; a simultaneous accepted write and read cancel out
    always_comb begin
        count_nxt_s = count_r;
        case ({wr_accept_s, rd_accept_s})
            2'b10:   count_nxt_s = count_r + PW'(1);
            2'b01:   count_nxt_s = count_r - PW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // pointers, count and per-request responses
    always_ff @(posedge wr_clk) begin
        if (clear) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {PW{1'b0}};
            wr_ack_r <= 1'b0;
            wr_err_r <= 1'b0;
            rd_ack_r <= 1'b0;
            rd_err_r <= 1'b0;
        end else begin
            count_r  <= count_nxt_s;
            if (wr_accept_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (rd_accept_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            wr_ack_r <= wr_accept_s;
            wr_err_r <= fif.wr_en & full_s;
            rd_ack_r <= rd_accept_s;
            rd_err_r <= fif.rd_en & empty_s;
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (wr_clk),
        .clear (clear),
        .we    (wr_accept_s & ~clear),
        .waddr (wr_ptr_r[AW-1:0]),
        .wdata (fif.din),
        .re    (rd_accept_s & ~clear),
        .raddr (rd_ptr_r[AW-1:0]),
        .rdata (fif.dout)
    );

    assign fif.full         = full_s;
    assign fif.almost_full  = almost_full_s;
    assign fif.empty        = empty_s;
    assign fif.almost_empty = almost_empty_s;
    assign fif.wr_ack       = wr_ack_r;
    assign fif.wr_err       = wr_err_r;
    assign fif.rd_ack       = rd_ack_r;
    assign fif.rd_err       = rd_err_r;

`ifdef DATA_COUNT_EN
    assign data_count = count_r;
`endif

endmodule

// File: tb/tb_fifo_modport.sv
// Scoreboard bench for fifo_modport: a queue-based model predicts each cycle's response, a monitor compares.
module tb_fifo_modport;
    import fifo_pkg::*;

    localparam int WIDTH = WIDTH_DEF;
    localparam int DEPTH = DEPTH_DEF;
    localparam int PW    = addr_w(DEPTH) + 1;

    logic wr_clk = 1'b0;
    logic clear;
    always #5 wr_clk = ~wr_clk;

    fifo_if #(.WIDTH(WIDTH)) fif ();

`ifdef DATA_COUNT_EN
    logic [PW-1:0] data_count;
`endif

    fifo_modport #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .wr_clk     (wr_clk),
        .clear      (clear),
        .fif        (fif)
`ifdef DATA_COUNT_EN
        ,
        .data_count (data_count)
`endif
    );

    typedef struct {
        logic             wr_ack;
        logic             wr_err;
        logic             rd_ack;
        logic             rd_err;
        logic [WIDTH-1:0] dout;
        int               cnt;
    } exp_t;

    exp_t             sb[$];
    logic [WIDTH-1:0] model[$];
    logic [WIDTH-1:0] last_dout;
    int               checks;
    int               errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // drive one cycle of stimulus and push the model's prediction for that edge
    task automatic step(input logic w, input logic r, input logic clr, input logic [WIDTH-1:0] d);
        exp_t e;
        bit   was_full;
        bit   was_empty;
        @(negedge wr_clk);
        fif.wr_en = w;
        fif.rd_en = r;
        fif.din   = d;
        clear     = clr;
        if (clr) begin
            model.delete();
            last_dout = '0;
            e.wr_ack = 1'b0; e.wr_err = 1'b0; e.rd_ack = 1'b0; e.rd_err = 1'b0;
        end else begin
            was_full  = (model.size() == DEPTH);
            was_empty = (model.size() == 0);
            e.wr_ack  = w && !was_full;
            e.wr_err  = w && was_full;
            e.rd_ack  = r && !was_empty;
            e.rd_err  = r && was_empty;
            if (e.rd_ack) last_dout = model.pop_front();
            if (e.wr_ack) model.push_back(d);
        end
        e.dout = last_dout;
        e.cnt  = model.size();
        sb.push_back(e);
    endtask

    // monitor: one prediction is consumed per clock edge once stimulus has started
    initial begin
        exp_t e;
        forever begin
            @(posedge wr_clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("wr_ack",       fif.wr_ack,       e.wr_ack);
                chk("wr_err",       fif.wr_err,       e.wr_err);
                chk("rd_ack",       fif.rd_ack,       e.rd_ack);
                chk("rd_err",       fif.rd_err,       e.rd_err);
                chk("dout",         fif.dout,         e.dout);
                chk("empty",        fif.empty,        (e.cnt == 0));
                chk("almost_empty", fif.almost_empty, (e.cnt <= 1));
                chk("full",         fif.full,         (e.cnt == DEPTH));
                chk("almost_full",  fif.almost_full,  (e.cnt >= DEPTH - 1));
`ifdef DATA_COUNT_EN
                chk("data_count",   data_count,       e.cnt);
`endif
            end
        end
    end

    initial begin
        checks    = 0;
        errors    = 0;
        last_dout = '0;
        fif.wr_en = 1'b0;
        fif.rd_en = 1'b0;
        fif.din   = '0;
        clear     = 1'b0;

        // reset with both requests asserted
        repeat (2) step(1'b1, 1'b1, 1'b1, 8'h55);

        // fill, overflow, drain, underflow
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, WIDTH'(i));
        step(1'b1, 1'b0, 1'b0, 8'hAA);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h00);

        // simultaneous on empty, at 8, on full
        step(1'b1, 1'b1, 1'b0, 8'h80);
        for (int i = 1; i < 8; i++) step(1'b1, 1'b0, 1'b0, WIDTH'(8'h80 + i));
        for (int i = 8; i < 11; i++) step(1'b1, 1'b1, 1'b0, WIDTH'(8'h80 + i));
        for (int i = 11; i < 19; i++) step(1'b1, 1'b0, 1'b0, WIDTH'(8'h80 + i));
        step(1'b1, 1'b1, 1'b0, 8'hEE);
        for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 1'b1, 1'b0, 8'h00);

        // wrap: interleaved write/read pairs
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b0, 1'b0, WIDTH'(8'hC0 + i));
            step(1'b0, 1'b1, 1'b0, 8'h00);
        end

        // mid-operation clear at count 10
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, WIDTH'(8'h30 + i));
        step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h00);

        // randomized traffic with occasional clear
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 63) == 0), WIDTH'($urandom));
        end
        step(1'b0, 1'b0, 1'b0, 8'h00);

        for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge wr_clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d predictions left, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
